weight_read_controller: RTL and testbench
=========================================

// Module: weight_read_controller
// PURPOSE
//  Read-side stage of the weight path. Consumes the read bank of the weight double buffer.
//  After the bank switch, streams NUM_ADDR words NUM_PASS times to the PE array via ren/raddr.
//  Reports completion to the main FSM and takes the switch pulse that swaps banks.
//  Mirrors the write-side input controller: write side fills one bank while this block drains the other.
// PARAMETERS
//  OC0             4   weight vector lanes per buffer word (rdata_out = 16*OC0 bits)
//  CONFIG_WIDTH    32  config word width; [15:0]=NUM_ADDR, [31:16]=NUM_PASS
//  BANK_ADDR_WIDTH 32  buffer read address width
//  COUNTER_WID     16  width of address/pass/bank counters
// PORTS
//  clk                       in   1               clock, all state on posedge
//  rst_n                     in   1               async active-low reset
//  config_enable             in   1               load config_data (IDLE only)
//  config_data               in   CONFIG_WIDTH    NUM_ADDR / NUM_PASS
//  switch                    in   1               1-cycle bank swap pulse from main FSM
//  rd_rdy                    in   1               consumer accepts a word this cycle
//  ren                       out  1               buffer read enable
//  raddr                     out  BANK_ADDR_WIDTH buffer read address
//  rdata                     in   16*OC0          buffer read data (1-cycle SRAM latency)
//  rdata_out                 out  16*OC0          registered rdata to consumer
//  rdata_vld                 out  1               rdata_out valid
//  read_bank_ready_to_switch out  1               bank drained, waiting for switch
//  read_bank_count           out  COUNTER_WID     banks fully consumed, wraps at 2^COUNTER_WID
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, NUM_ADDR=NUM_PASS=1.
//  States:
//   IDLE    --config_enable--> WAIT_SW (latch cfg; a 0 field is stored as 1)
//   WAIT_SW --switch-->        READ (addr=0, pass=0)
//   READ    --last fire-->     DONE
//   DONE    --1 cycle-->       WAIT_SW
//  READ: ren = rd_rdy (combinational); raddr = addr counter.
//   Fire = ren. Each fire: addr++.
//   addr == NUM_ADDR-1: addr wraps to 0 and pass++.
//   Last fire: addr == NUM_ADDR-1 and pass == NUM_PASS-1.
//   rd_rdy low: ren=0; addr/pass hold (stall, no bubble penalty).
//  Data path: rdata_vld = ren delayed 1 cycle; rdata_out = rdata captured when that delayed ren is high.
//   Read-to-rdata_vld latency = 2 cycles (1 SRAM + 1 output register).
//  DONE cycle: read_bank_count++.
//   read_bank_ready_to_switch set on the next edge; stays high through WAIT_SW.
//   Cleared on the edge after switch is sampled.
//  Initial WAIT_SW after config: read_bank_ready_to_switch=1, so the main FSM may perform
//   the first swap once the write side is ready.
//  Ignored inputs: switch outside WAIT_SW; config_enable outside IDLE.
//  Simultaneous events:
//   switch and config_enable in the same cycle in WAIT_SW: switch wins.
//   rd_rdy in the DONE/WAIT_SW cycle: ren stays 0.
//  Reset mid-READ: ren drops immediately (async); the partial bank is lost; config must be reloaded.
//  No re-config while running; return to IDLE only via rst_n.
// TESTING
//  1 Reset: hold rst_n=0 mid-stream -> ren, rdata_vld, ready_to_switch, count all 0 without waiting for clk.
//  2 Config NUM_ADDR=4, NUM_PASS=2; switch; rd_rdy=1 ->
//     raddr 0,1,2,3,0,1,2,3 on 8 consecutive cycles; rdata_vld 2 cycles after each;
//     count=1; ready_to_switch high 2 cycles after last ren.
//  3 Same config, rd_rdy toggles 1010... ->
//     exactly 8 fires, address order unchanged, rdata_out matches model SRAM contents.
//  4 Config NUM_ADDR=0, NUM_PASS=0 -> treated 1/1: single ren at raddr=0 then DONE.
//  5 switch pulsed during READ and in IDLE -> no effect; raddr sequence intact.
//     Three banks back-to-back -> count=3.
//  6 Config 3/1; switch and config_enable asserted in the same cycle ->
//     READ entered, config unchanged, raddr 0,1,2.

Source files
------------

// File: rtl/weight_read_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_read_controller_if
// Description : Read-bank bus between the weight read controller, the weight
//               double-buffer SRAM read port and the PE-array consumer.
//               master = controller, slave = buffer/consumer side.
// Ports       : rd_rdy    consumer accepts a word this cycle
//               ren       buffer read enable
//               raddr     buffer read address
//               rdata     buffer read data (1-cycle SRAM latency)
//               rdata_out registered read data to the consumer
//               rdata_vld rdata_out valid
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_read_controller_if #(
    parameter int OC0             = 4,
    parameter int BANK_ADDR_WIDTH = 32
);
    logic                       rd_rdy;
    logic                       ren;
    logic [BANK_ADDR_WIDTH-1:0] raddr;
    logic [16*OC0-1:0]          rdata;
    logic [16*OC0-1:0]          rdata_out;
    logic                       rdata_vld;

    modport master (
        input  rd_rdy, rdata,
        output ren, raddr, rdata_out, rdata_vld
    );

    modport slave (
        output rd_rdy, rdata,
        input  ren, raddr, rdata_out, rdata_vld
    );
endinterface
`default_nettype wire

// File: rtl/weight_read_controller.sv
`default_nettype none
// ============================================================================
// Module      : weight_read_controller
// Description : Read side of the weight double buffer. After each bank swap
//               it streams NUM_ADDR words NUM_PASS times to the PE array,
//               then reports the bank drained and waits for the next swap.
// Ports       : clk, rst_n                 clock, async active-low reset
//               config_enable, config_data load NUM_ADDR[15:0]/NUM_PASS[31:16]
//               switch                     1-cycle bank swap pulse
//               read_bank_ready_to_switch  bank drained, waiting for switch
//               read_bank_count            banks fully consumed (wraps)
//               rd                         read bus (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module weight_read_controller #(
    parameter int OC0             = 4,
    parameter int CONFIG_WIDTH    = 32,
    parameter int BANK_ADDR_WIDTH = 32,
    parameter int COUNTER_WID     = 16
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    config_enable,
    input  wire logic [CONFIG_WIDTH-1:0] config_data,
    input  wire logic                    switch,
    output logic                         read_bank_ready_to_switch,
    output logic [COUNTER_WID-1:0]       read_bank_count,
    weight_read_controller_if.master     rd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_SW = 2'd1,
        READ    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    fire;
    logic                    last_addr;
    logic                    last_pass;

    logic [COUNTER_WID-1:0]  num_addr;
    logic [COUNTER_WID-1:0]  num_pass;
    logic [COUNTER_WID-1:0]  addr;
    logic [COUNTER_WID-1:0]  pass;
    logic [COUNTER_WID-1:0]  cfg_addr_field;
    logic [COUNTER_WID-1:0]  cfg_pass_field;

    logic                    ren_d1;
    logic                    vld;
    logic [16*OC0-1:0]       data_out;

    assign cfg_addr_field = COUNTER_WID'(config_data[15:0]);
    assign cfg_pass_field = COUNTER_WID'(config_data[31:16]);

    assign last_addr = (addr == num_addr - COUNTER_WID'(1));
    assign last_pass = (pass == num_pass - COUNTER_WID'(1));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and read enable. ren is purely combinational from the state,
    // so an asynchronous reset drops it without waiting for a clock edge.
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (config_enable) next_state = WAIT_SW;
            end
            WAIT_SW: begin
                // switch takes priority over config_enable: config is IDLE-only
                if (switch) next_state = READ;
            end
            READ: begin
                fire = rd.rd_rdy;
                if (fire && last_addr && last_pass) next_state = DONE;
            end
            DONE: begin
                next_state = WAIT_SW;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Config, address/pass counters, bank bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_addr                  <= COUNTER_WID'(1);
            num_pass                  <= COUNTER_WID'(1);
            addr                      <= '0;
            pass                      <= '0;
            read_bank_ready_to_switch <= 1'b0;
            read_bank_count           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (config_enable) begin
                        // A zero count would never terminate; treat it as one.
                        num_addr <= (cfg_addr_field == '0) ? COUNTER_WID'(1) : cfg_addr_field;
                        num_pass <= (cfg_pass_field == '0) ? COUNTER_WID'(1) : cfg_pass_field;
                        // First swap may proceed as soon as the write side is ready.
                        read_bank_ready_to_switch <= 1'b1;
                    end
                end
                WAIT_SW: begin
                    if (switch) begin
                        addr                      <= '0;
                        pass                      <= '0;
                        read_bank_ready_to_switch <= 1'b0;
                    end
                end
                READ: begin
                    if (fire) begin
                        if (last_addr) begin
                            addr <= '0;
                            pass <= pass + COUNTER_WID'(1);
                        end else begin
                            addr <= addr + COUNTER_WID'(1);
                        end
                    end
                end
                DONE: begin
                    read_bank_count           <= read_bank_count + COUNTER_WID'(1);
                    read_bank_ready_to_switch <= 1'b1;
                end
                default: begin
                    addr <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Data path: one cycle of SRAM latency (ren_d1 marks rdata valid), then
    // the output register, giving ren -> rdata_vld of two cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_d1   <= 1'b0;
            vld      <= 1'b0;
            data_out <= '0;
        end else begin
            ren_d1 <= fire;
            vld    <= ren_d1;
            if (ren_d1) begin
                data_out <= rd.rdata;
            end
        end
    end

    assign rd.ren       = fire;
    assign rd.rdata_vld = vld;
    assign rd.rdata_out = data_out;

    generate
        if (BANK_ADDR_WIDTH > COUNTER_WID) begin : g_raddr_pad
            assign rd.raddr = {{(BANK_ADDR_WIDTH-COUNTER_WID){1'b0}}, addr};
        end else begin : g_raddr_trunc
            assign rd.raddr = addr[BANK_ADDR_WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_weight_read_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_read_controller
// Description : Directed self-checking bench for weight_read_controller with a
//               behavioural 1-cycle-latency SRAM on the read bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_read_controller;

    localparam int OC0             = 4;
    localparam int CONFIG_WIDTH    = 32;
    localparam int BANK_ADDR_WIDTH = 32;
    localparam int COUNTER_WID     = 16;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    config_enable;
    logic [CONFIG_WIDTH-1:0] config_data;
    logic                    switch;
    logic                    ready;
    logic [COUNTER_WID-1:0]  count;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  rdy_rise = -1;
    logic ready_prev = 1'b0;
    ev_t ren_q[$];
    ev_t vld_q[$];

    weight_read_controller_if #(.OC0(OC0), .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH)) rd ();

    weight_read_controller #(
        .OC0             (OC0),
        .CONFIG_WIDTH    (CONFIG_WIDTH),
        .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH),
        .COUNTER_WID     (COUNTER_WID)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .config_enable             (config_enable),
        .config_data               (config_data),
        .switch                    (switch),
        .read_bank_ready_to_switch (ready),
        .read_bank_count           (count),
        .rd                        (rd)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sram_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0] + 16'h0100, ~a[15:0], a[15:0] * 16'd3};
    endfunction

    // Behavioural SRAM: data appears the cycle after ren
    always @(posedge clk) begin
        if (rd.ren) rd.rdata <= sram_word(rd.raddr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples one time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (rd.ren)       ren_q.push_back('{cyc, 64'(rd.raddr)});
            if (rd.rdata_vld) vld_q.push_back('{cyc, rd.rdata_out});
            if (ready && !ready_prev) rdy_rise = cyc;
            ready_prev = ready;
        end else begin
            ready_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        config_enable = 1'b0;
        config_data   = '0;
        switch        = 1'b0;
        rd.rd_rdy     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ren_q.delete();
        vld_q.delete();
    endtask

    task automatic do_config(input logic [15:0] na, input logic [15:0] np);
        @(negedge clk);
        config_enable = 1'b1;
        config_data   = {np, na};
        @(negedge clk);
        config_enable = 1'b0;
        config_data   = '0;
    endtask

    task automatic pulse_switch();
        @(negedge clk);
        switch = 1'b1;
        @(negedge clk);
        switch = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        check({tag, "_ready_timeout"}, ready, 1'b1);
    endtask

    // Compare a recorded bank against NUM_ADDR x NUM_PASS reads of the model
    task automatic check_bank(input string tag, input int na, input int np, input bit contiguous);
        int n;
        n = na * np;
        check({tag, "_nren"}, ren_q.size(), n);
        check({tag, "_nvld"}, vld_q.size(), n);
        for (int i = 0; i < n && i < ren_q.size(); i++) begin
            check($sformatf("%s_raddr%0d", tag, i), ren_q[i].val, i % na);
            if (contiguous)
                check($sformatf("%s_rcyc%0d", tag, i), ren_q[i].cyc, ren_q[0].cyc + i);
            if (i < vld_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), vld_q[i].val, sram_word(i % na));
                check($sformatf("%s_lat%0d", tag, i), vld_q[i].cyc, ren_q[i].cyc + 2);
            end
        end
        ren_q.delete();
        vld_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_ren;

        // ---------------- reset state ----------------
        rst_n = 1'b0; config_enable = 1'b0; config_data = '0; switch = 1'b0; rd.rd_rdy = 1'b0;
        @(negedge clk);
        check("rst_ren",   rd.ren, 1'b0);
        check("rst_vld",   rd.rdata_vld, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_count", count, '0);
        check("rst_raddr", rd.raddr, '0);
        do_reset();

        // ---------------- 4x2, rd_rdy held high ----------------
        do_config(16'd4, 16'd2);
        check("t2_ready_init", ready, 1'b1);
        rd.rd_rdy = 1'b1;
        ren_q.delete(); vld_q.delete();
        pulse_switch();
        repeat (3) @(negedge clk);
        check("t2_ready_in_read", ready, 1'b0);
        wait_ready("t2");
        repeat (3) @(negedge clk);
        last_ren = (ren_q.size() > 0) ? ren_q[ren_q.size()-1].cyc : -100;
        check("t2_ready_rise", rdy_rise, last_ren + 2);
        check_bank("t2", 4, 2, 1'b1);
        check("t2_count", count, 16'd1);

        // ---------------- same config, rd_rdy 1010... ----------------
        rd.rd_rdy = 1'b0;
        pulse_switch();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rd.rd_rdy = (i % 2 == 0);
        end
        rd.rd_rdy = 1'b0;
        wait_ready("t3");
        repeat (3) @(negedge clk);
        check_bank("t3", 4, 2, 1'b0);
        check("t3_count", count, 16'd2);

        // ---------------- async reset mid-stream ----------------
        rd.rd_rdy = 1'b1;
        pulse_switch();
        repeat (3) @(negedge clk);
        #1;
        check("t1_pre_ren", rd.ren, 1'b1);
        check("t1_pre_vld", rd.rdata_vld, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t1_async_ren",   rd.ren, 1'b0);
        check("t1_async_vld",   rd.rdata_vld, 1'b0);
        check("t1_async_ready", ready, 1'b0);
        check("t1_async_count", count, '0);
        check("t1_async_raddr", rd.raddr, '0);
        do_reset();

        // ---------------- zero config treated as 1/1 ----------------
        do_config(16'd0, 16'd0);
        check("t4_ready_init", ready, 1'b1);
        rd.rd_rdy = 1'b1;
        pulse_switch();
        wait_ready("t4");
        repeat (3) @(negedge clk);
        check_bank("t4", 1, 1, 1'b1);
        check("t4_count", count, 16'd1);

        // ---------------- ignored switch/config, back-to-back banks ----------------
        do_reset();
        rd.rd_rdy = 1'b1;
        pulse_switch();
        repeat (4) @(negedge clk);
        check("t5_idle_nren", ren_q.size(), 0);
        check("t5_idle_ready", ready, 1'b0);
        do_config(16'd4, 16'd2);
        pulse_switch();
        repeat (3) @(negedge clk);
        switch = 1'b1;
        @(negedge clk);
        switch = 1'b0;
        wait_ready("t5a");
        repeat (3) @(negedge clk);
        check_bank("t5a", 4, 2, 1'b1);
        do_config(16'd1, 16'd1);
        pulse_switch();
        wait_ready("t5b");
        repeat (3) @(negedge clk);
        check_bank("t5b", 4, 2, 1'b1);
        pulse_switch();
        wait_ready("t5c");
        repeat (3) @(negedge clk);
        check_bank("t5c", 4, 2, 1'b1);
        check("t5_count", count, 16'd3);

        // ---------------- switch and config_enable together ----------------
        do_reset();
        do_config(16'd3, 16'd1);
        rd.rd_rdy = 1'b1;
        @(negedge clk);
        switch        = 1'b1;
        config_enable = 1'b1;
        config_data   = {16'd2, 16'd5};
        @(negedge clk);
        switch        = 1'b0;
        config_enable = 1'b0;
        config_data   = '0;
        wait_ready("t6a");
        repeat (3) @(negedge clk);
        check_bank("t6a", 3, 1, 1'b1);
        check("t6_count", count, 16'd1);
        pulse_switch();
        wait_ready("t6b");
        repeat (3) @(negedge clk);
        check_bank("t6b", 3, 1, 1'b1);
        check("t6_count2", count, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
